seq_shifter: RTL and testbench

- Multi-cycle shift execution unit in the RISC datapath.
- Consumes the shift amount (sha) and out-of-range bypass flag (byp) produced by the shift-amount selection stage, together with the operand and shift opcode.
- Performs SLL/SRL/SRA/ROR iteratively, at most STEP bit positions per clock.
- Presents the result to writeback with a ready/start/done handshake.

---
 rtl/seq_shifter.sv | 127 ++++++++++++
 tb/tb_seq_shifter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit (SLL/SRL/SRA/ROR), at most STEP bit positions per clock.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset
//   start_i   request, accepted only while ready_o=1
//   data_i    operand to shift
//   sha_i     shift amount (0..31)
//   byp_i     register-supplied amount exceeded 31 (ignored for ROR)
//   op_i      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   flush_i   synchronous abort; beats start_i
//   ready_o   idle, can accept start
//   busy_o    shift in progress
//   done_o    one-cycle pulse, result_o valid
//   result_o  shifted value, held until the next accepted start
module seq_shifter #(
  parameter int unsigned STEP  = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       sha_i,
  input  logic             byp_i,
  input  logic [1:0]       op_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  localparam logic [4:0] StepAmt  = 5'(STEP);
  localparam logic [5:0] WidthAmt = 6'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rem_q, rem_d;
  logic [1:0]       op_q, op_d;

  logic [4:0]       k;
  logic [WIDTH-1:0] shifted;

  // Bits moved this cycle: the whole remainder once it fits in one step.
  assign k = (rem_q < StepAmt) ? rem_q : StepAmt;

  always_comb begin
    shifted = result_q;
    unique case (op_q)
      OpSll:   shifted = result_q << k;
      OpSrl:   shifted = result_q >> k;
      OpSra:   shifted = $signed(result_q) >>> k;
      // k is never 0 while shifting, so the left part never shifts by WIDTH then.
      default: shifted = (result_q >> k) | (result_q << (WidthAmt - {1'b0, k}));
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    unique case (state_q)
      StIdle: begin
        if (!flush_i && start_i) begin
          op_d = op_i;
          if (byp_i && (op_i != OpRor)) begin
            result_d = (op_i == OpSra) ? {WIDTH{data_i[WIDTH-1]}} : '0;
            rem_d    = '0;
            state_d  = StDone;
          end else if (sha_i == 5'd0) begin
            result_d = data_i;
            rem_d    = '0;
            state_d  = StDone;
          end else begin
            result_d = data_i;
            rem_d    = sha_i;
            state_d  = StShift;
          end
        end
      end
      StShift: begin
        if (flush_i) begin
          // Partial result is left as-is; it is simply never flagged valid.
          rem_d   = '0;
          state_d = StIdle;
        end else begin
          result_d = shifted;
          rem_d    = rem_q - k;
          if (rem_q == k) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= OpSll;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q == StShift);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: five instances (STEP = 1,2,4,8,16) share operand inputs; each has its
// own start. Results and done latency are compared with an arithmetic reference model.
module tb_seq_shifter;

  localparam int N = 5;

  logic             clk;
  logic             rst;
  logic [N-1:0]     start_m;
  logic [31:0]      data;
  logic [4:0]       sha;
  logic             byp;
  logic [1:0]       op;
  logic             flush;
  logic             ready_v [N];
  logic             busy_v  [N];
  logic             done_v  [N];
  logic [31:0]      result_v[N];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_shifter #(
      .STEP (1 << g),
      .WIDTH(32)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start_m[g]),
      .data_i  (data),
      .sha_i   (sha),
      .byp_i   (byp),
      .op_i    (op),
      .flush_i (flush),
      .ready_o (ready_v[g]),
      .busy_o  (busy_v[g]),
      .done_o  (done_v[g]),
      .result_o(result_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Reference: the full shift computed in one go from the operation definition.
  function automatic logic [31:0] ref_result(input logic [31:0] d, input int s, input logic b,
                                             input logic [1:0] o);
    logic [63:0] two;
    if (b && o != 2'b11) return (o == 2'b10) ? (d[31] ? 32'hFFFF_FFFF : 32'h0) : 32'h0;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: begin
        two = {d, d} >> s;
        return two[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input int step, input int s, input logic b, input logic [1:0] o);
    if (b && o != 2'b11) return 1;
    return (s + step - 1) / step + 1;
  endfunction

  // Start all instances at once and check each result, latency and busy-cycle count.
  // Called at #1 after a clock edge with every instance idle.
  task automatic run(input string tag, input logic [31:0] d, input logic [4:0] s, input logic b,
                     input logic [1:0] o);
    int lat [N];
    int bcnt[N];
    logic [31:0] res[N];
    bit all;
    data = d; sha = s; byp = b; op = o;
    start_m = '1;
    for (int i = 0; i < N; i++) begin lat[i] = 0; bcnt[i] = 0; res[i] = 'x; end
    @(posedge clk); #1;
    start_m = '0;
    // Scramble operands after the accept edge; the unit must have captured them.
    data = $urandom; sha = 5'($urandom); byp = 1'($urandom); op = 2'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      all = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (lat[i] == 0) begin
          if (busy_v[i]) bcnt[i]++;
          if (done_v[i]) begin
            lat[i] = cyc;
            res[i] = result_v[i];
          end
        end
        if (lat[i] == 0) all = 1'b0;
      end
      if (all) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s lat step%0d", tag, 1 << i), 32'(lat[i]),
            32'(ref_lat(1 << i, int'(s), b, o)));
      check($sformatf("%s busy step%0d", tag, 1 << i), 32'(bcnt[i]),
            32'(ref_lat(1 << i, int'(s), b, o) - 1));
      check($sformatf("%s result step%0d", tag, 1 << i), res[i], ref_result(d, int'(s), b, o));
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s ready step%0d", tag, 1 << i), 32'(ready_v[i]), 32'd1);
      check($sformatf("%s done low step%0d", tag, 1 << i), 32'(done_v[i]), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    int seen;
    rst = 1'b1; start_m = '0; data = '0; sha = '0; byp = 1'b0; op = '0; flush = 1'b0;
    #12;
    check("reset ready", 32'(ready_v[2]), 32'd1);
    check("reset busy", 32'(busy_v[2]), 32'd0);
    check("reset done", 32'(done_v[2]), 32'd0);
    check("reset result", result_v[2], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run("sll31", 32'h0000_0001, 5'd31, 1'b0, 2'b00);
    run("sra4", 32'hF000_0000, 5'd4, 1'b0, 2'b10);
    run("srl4", 32'hF000_0000, 5'd4, 1'b0, 2'b01);
    run("byp sra", 32'h8000_0000, 5'd7, 1'b1, 2'b10);
    run("byp srl", 32'h8000_0000, 5'd7, 1'b1, 2'b01);
    run("byp ror", 32'h8000_0000, 5'd7, 1'b1, 2'b11);
    run("zero", 32'h1234_5678, 5'd0, 1'b0, 2'b00);

    // Start while busy is ignored (STEP=4 instance only).
    data = 32'h0000_0003; sha = 5'd9; op = 2'b00; byp = 1'b0;
    start_m = 5'b00100;
    @(posedge clk); #1;
    start_m = '0;
    @(posedge clk); #1;
    data = 32'hFFFF_FFFF; sha = 5'd1; op = 2'b01;
    start_m = 5'b00100;
    @(posedge clk); #1;
    start_m = '0;
    cnt = 3;
    while (!done_v[2] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ign lat", 32'(cnt), 32'd4);
    check("ign result", result_v[2], 32'h0000_0600);
    @(posedge clk); #1;
    check("ign ready", 32'(ready_v[2]), 32'd1);
    @(posedge clk); #1;
    check("ign no requeue", 32'(busy_v[2]), 32'd0);
    check("ign held", result_v[2], 32'h0000_0600);

    // Flush on the second shift cycle.
    data = 32'h0000_0001; sha = 5'd20; op = 2'b00;
    start_m = 5'b00100;
    @(posedge clk); #1;
    start_m = '0;
    check("flush busy", 32'(busy_v[2]), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush ready", 32'(ready_v[2]), 32'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_v[2] || busy_v[2]) seen++;
      @(posedge clk); #1;
    end
    check("flush no done", 32'(seen), 32'd0);

    // Flush beats start in the idle state.
    data = 32'h0000_0001; sha = 5'd0; op = 2'b00;
    start_m = 5'b00100; flush = 1'b1;
    @(posedge clk); #1;
    start_m = '0; flush = 1'b0;
    check("flush beats start", 32'(done_v[2]), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation.
    data = 32'h0000_0001; sha = 5'd20; op = 2'b00;
    start_m = 5'b00100;
    @(posedge clk); #1;
    start_m = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst result", result_v[2], 32'h0);
    check("rst done", 32'(done_v[2]), 32'd0);
    check("rst ready", 32'(ready_v[2]), 32'd1);
    check("rst busy", 32'(busy_v[2]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Random sweep across all STEP values.
    for (int t = 0; t < 40; t++) begin
      run($sformatf("rnd%0d", t), $urandom, 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
